button_event_unit: RTL

//  Converts a vector of debounced button levels into a queued stream of press/release/repeat

---
 rtl/button_event_pkg.sv | 17 +
 rtl/button_event_fifo.sv | 58 +++++
 rtl/button_event_unit.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/button_event_pkg.sv
// Shared event encoding for the button event unit and its queue.
package button_event_pkg;

   localparam int EVENT_TYPE_WIDTH = 2;

   typedef enum logic [EVENT_TYPE_WIDTH-1:0] {
      EVENT_NONE    = 2'b00,
      EVENT_PRESS   = 2'b01,
      EVENT_RELEASE = 2'b10,
      EVENT_REPEAT  = 2'b11
   } event_type_t;

   function automatic event_type_t edge_type(input logic level);
      return level ? EVENT_PRESS : EVENT_RELEASE;
   endfunction

endpackage

// File: rtl/button_event_fifo.sv
// Synchronous event queue: registered occupancy count, head read straight from storage.
module button_event_fifo #(
   parameter int width     = 4,
   parameter int depthLog2 = 2
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             push,
   input  logic [width-1:0] push_data,
   input  logic             pop,
   output logic [width-1:0] head,
   output logic             full,
   output logic             empty
);

   localparam int depth = 2 ** depthLog2;

   logic [width-1:0]     mem [depth];
   logic [depthLog2-1:0] wr_ptr_reg;
   logic [depthLog2-1:0] rd_ptr_reg;
   logic [depthLog2:0]   count_reg;
   logic                 do_push;
   logic                 do_pop;

   // Full comes from the registered count, so a pop never frees space for a same-cycle push.
   assign full    = (count_reg == (depthLog2 + 1)'(depth));
   assign empty   = (count_reg == '0);
   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;
   assign head    = mem[rd_ptr_reg];

   always_ff @(posedge clock) begin
      if (do_push) begin
         mem[wr_ptr_reg] <= push_data;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr_reg <= wr_ptr_reg + 1'b1;
         end
         if (do_pop) begin
            rd_ptr_reg <= rd_ptr_reg + 1'b1;
         end
         case ({do_push, do_pop})
            2'b10:   count_reg <= count_reg + 1'b1;
            2'b01:   count_reg <= count_reg - 1'b1;
            default: count_reg <= count_reg;
         endcase
      end
   end

endmodule

// File: rtl/button_event_unit.sv
// Turns debounced button levels into queued press/release(/repeat) events with valid/ready.
// Auto-repeat and the overflow flag exist only when BUTTON_EVENT_AUTO_REPEAT_EN is defined.
module button_event_unit
   import button_event_pkg::*;
#(
   parameter int                      buttonCount   = 4,
   parameter int                      indexWidth    = 2,
   parameter int                      fifoDepthLog2 = 2,
   parameter int                      counterWidth  = 24,
   parameter logic [counterWidth-1:0] repeatDelay   = 24'd12500000,
   parameter logic [counterWidth-1:0] repeatPeriod  = 24'd2500000
) (
   input  logic                        clock,
   input  logic                        reset,
   input  logic [buttonCount-1:0]      buttons,
   output logic                        eventValid,
   input  logic                        eventReady,
   output logic [EVENT_TYPE_WIDTH-1:0] eventType,
   output logic [indexWidth-1:0]       eventIndex,
   output logic                        overflow,
   input  logic                        clearOverflow
);

   localparam int entryWidth = EVENT_TYPE_WIDTH + indexWidth;

   logic [buttonCount-1:0] prev_reg;
   logic [buttonCount-1:0] prev_next;
   logic [buttonCount-1:0] pending;
   logic                   edge_found;
   logic [indexWidth-1:0]  edge_index;
   logic                   edge_push;
   logic                   push;
   logic [entryWidth-1:0]  push_data;
   logic [entryWidth-1:0]  head;
   logic                   fifo_full;
   logic                   fifo_empty;

   assign pending = buttons ^ prev_reg;

   // Lowest changed index wins; scanning downward lets the last hit be the lowest.
   always_comb begin
      edge_found = 1'b0;
      edge_index = '0;
      for (int i = buttonCount - 1; i >= 0; i--) begin
         if (pending[i]) begin
            edge_found = 1'b1;
            edge_index = indexWidth'(i);
         end
      end
   end

   // A change only retires from prev once its event is in the queue; otherwise it stays pending.
   assign edge_push = edge_found & ~fifo_full;

   always_comb begin
      prev_next = prev_reg;
      if (edge_push) begin
         prev_next[edge_index] = buttons[edge_index];
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         prev_reg <= '0;
      end else begin
         prev_reg <= prev_next;
      end
   end

`ifdef BUTTON_EVENT_AUTO_REPEAT_EN
   logic [counterWidth-1:0] timer_reg;
   logic [counterWidth-1:0] timer_next;
   logic [indexWidth-1:0]   target_reg;
   logic [indexWidth-1:0]   target_next;
   logic                    active_reg;
   logic                    active_next;
   logic                    overflow_reg;
   logic                    overflow_next;
   logic                    repeat_due;
   logic                    repeat_push;

   // Timer counts cycles left including the firing one, so a load of N fires N cycles later;
   // a value of 0 means a repeat deferred by an edge event is still owed.
   assign repeat_due = active_reg & prev_reg[target_reg] & (timer_reg <= counterWidth'(1));

   always_comb begin
      timer_next    = timer_reg;
      target_next   = target_reg;
      active_next   = active_reg;
      overflow_next = clearOverflow ? 1'b0 : overflow_reg;
      repeat_push   = 1'b0;
      if (active_reg && prev_reg[target_reg]) begin
         if (!repeat_due) begin
            timer_next = timer_reg - 1'b1;
         end else if (edge_push) begin
            timer_next = '0;
         end else if (fifo_full) begin
            timer_next    = repeatPeriod;
            overflow_next = 1'b1;
         end else begin
            timer_next  = repeatPeriod;
            repeat_push = 1'b1;
         end
      end
      if (edge_push && buttons[edge_index]) begin
         target_next = edge_index;
         timer_next  = repeatDelay;
         active_next = 1'b1;
      end else if (edge_push && (edge_index == target_reg)) begin
         active_next = 1'b0;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         timer_reg    <= '0;
         target_reg   <= '0;
         active_reg   <= 1'b0;
         overflow_reg <= 1'b0;
      end else begin
         timer_reg    <= timer_next;
         target_reg   <= target_next;
         active_reg   <= active_next;
         overflow_reg <= overflow_next;
      end
   end

   assign push      = edge_push | repeat_push;
   assign push_data = edge_push ? {edge_type(buttons[edge_index]), edge_index}
                                : {EVENT_REPEAT, target_reg};
   assign overflow  = overflow_reg;
`else
   logic unused_repeat_cfg;

   assign unused_repeat_cfg = ^{clearOverflow, repeatDelay, repeatPeriod};
   assign push              = edge_push;
   assign push_data         = {edge_type(buttons[edge_index]), edge_index};
   assign overflow          = 1'b0;
`endif

   button_event_fifo #(
      .width     (entryWidth),
      .depthLog2 (fifoDepthLog2)
   ) event_queue (
      .clock     (clock),
      .reset     (reset),
      .push      (push),
      .push_data (push_data),
      .pop       (eventReady),
      .head      (head),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

   // Head fields read as zero while the queue is empty rather than exposing stale storage.
   assign eventValid = ~fifo_empty;
   assign eventType  = fifo_empty ? EVENT_TYPE_WIDTH'(0) : head[entryWidth-1 -: EVENT_TYPE_WIDTH];
   assign eventIndex = fifo_empty ? indexWidth'(0) : head[indexWidth-1:0];

endmodule
